aes_block_sequencer: RTL and testbench

Upstream feeder for the AES-256 encrypt path. It buffers 128-bit plaintext blocks from a producer in a small FIFO and holds the session key. It issues one block at a time to the SPI master's `from_Real_msg`/`from_Real_key`/`valid_curr_data` inputs, waits for the core's completion pulse, and returns each ciphertext on a valid/ready output. This lets the encrypt/decrypt wrappers process a stream of blocks instead of a single hard-wired vector.

---
 rtl/aes_block_sequencer_if.sv | 42 ++++
 rtl/aes_block_sequencer.sv | 175 +++++++++++++++++
 tb/tb_aes_block_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_sequencer_if.sv
// aes_block_sequencer_if: key, plaintext, core and ciphertext signals
// of the AES block sequencer, bundled into one port.
interface aes_block_sequencer_if #(
    parameter int NK    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [32*NK-1:0] key_in;
    logic             key_load;
    logic             key_ready;
    logic [127:0]     pt_data;
    logic             pt_valid;
    logic             pt_ready;
    logic [127:0]     msg_out;
    logic [32*NK-1:0] key_out;
    logic             msg_valid;
    logic             core_done;
    logic [127:0]     core_data;
    logic [127:0]     ct_data;
    logic             ct_valid;
    logic             ct_ready;
    logic [CW-1:0]    fifo_count;
    logic [15:0]      blocks_done;
    logic             timeout_err;

    modport slave (
        input  key_in, key_load, pt_data, pt_valid,
        input  core_done, core_data, ct_ready,
        output key_ready, pt_ready, msg_out, key_out,
        output msg_valid, ct_data, ct_valid,
        output fifo_count, blocks_done, timeout_err
    );

    modport master (
        output key_in, key_load, pt_data, pt_valid,
        output core_done, core_data, ct_ready,
        input  key_ready, pt_ready, msg_out, key_out,
        input  msg_valid, ct_data, ct_valid,
        input  fifo_count, blocks_done, timeout_err
    );
endinterface

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: plaintext FIFO + key holder feeding the AES core.
// Optional WAIT watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_block_sequencer #(
    parameter int NK             = 8,
    parameter int NB             = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_block_sequencer_if.slave bus
);
    localparam int DW = 32 * NB;
    localparam int KW = 32 * NK;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (TIMEOUT_CYCLES < 2) || (NB != 4)) begin : g_cfg_err
        $error("aes_block_sequencer: unsupported parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] msg_q, msg_d;
    logic [KW-1:0] key_q, key_d;
    logic [DW-1:0] ct_q, ct_d;
    logic          mv_q, mv_d;
    logic          cv_q, cv_d;
    logic [15:0]   done_q, done_d;
    logic          pt_rdy;
    logic          push;
    logic          pop;
`ifdef AES_SEQ_TIMEOUT_EN
    logic [15:0]   wcnt_q, wcnt_d;
    logic          terr_q, terr_d;
`endif

    assign pt_rdy = (cnt_q != CW'(DEPTH));
    assign push   = bus.pt_valid & pt_rdy;

    // Next-state: issue from FIFO, wait for core, drain ciphertext
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        key_d   = key_q;
        ct_d    = ct_q;
        mv_d    = mv_q;
        cv_d    = cv_q;
        done_d  = done_q;
        pop     = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.key_load) begin
                    key_d = bus.key_in;
                end
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    msg_d   = mem_q[rp_q];
                    mv_d    = 1'b1;
                    state_d = S_WAIT;
`ifdef AES_SEQ_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    ct_d    = bus.core_data;
                    cv_d    = 1'b1;
                    mv_d    = 1'b0;
                    state_d = S_DRAIN;
`ifdef AES_SEQ_TIMEOUT_EN
                end else if (wcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    mv_d    = 1'b0;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 16'd1;
`endif
                end
            end
            S_DRAIN: begin
                if (bus.ct_ready) begin
                    cv_d    = 1'b0;
                    done_d  = done_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        wp_d  = push ? wp_q + AW'(1) : wp_q;
        rp_d  = pop ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // FIFO storage written on an accepted push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wp_q] <= bus.pt_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            msg_q   <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            mv_q    <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            mv_q    <= mv_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            terr_q <= terr_d;
        end
    end
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.key_ready   = (state_q == S_IDLE);
    assign bus.pt_ready    = pt_rdy;
    assign bus.msg_out     = msg_q;
    assign bus.key_out     = key_q;
    assign bus.msg_valid   = mv_q;
    assign bus.ct_data     = ct_q;
    assign bus.ct_valid    = cv_q;
    assign bus.fifo_count  = cnt_q;
    assign bus.blocks_done = done_q;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb_aes_block_sequencer: random stimulus against a queue-based
// transaction model, plus directed FIPS/full/backpressure/reset cases.
module tb_aes_block_sequencer;
    localparam int NK    = 8;
    localparam int DEPTH = 4;
`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TMO    = 32;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 4096;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_block_sequencer_if #(.NK(NK), .DEPTH(DEPTH)) bus ();

    aes_block_sequencer #(
        .NK(NK), .NB(4), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [127:0] mq[$];
    logic [127:0] m_msg, m_ct;
    logic [255:0] m_key;
    bit           m_mv, m_cv, m_terr, m_push;
    int           m_wc;
    logic [15:0]  m_done;

    int n_cmp = 0;
    int n_bad = 0;

    int p_push, p_key, p_ready, lat_lo, lat_hi;
    bit core_en, glitch, fips;
    int ctimer, clat;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_msg = '0; m_ct = '0; m_key = '0;
        m_mv = 0; m_cv = 0; m_terr = 0; m_push = 0;
        m_wc = 0; m_done = '0;
    endtask

    task automatic model_step();
        bit push;
        logic [127:0] pd;
        push   = bus.pt_valid && (mq.size() < DEPTH);
        pd     = bus.pt_data;
        m_push = push;
        if (!m_mv && !m_cv) begin
            if (bus.key_load) m_key = bus.key_in;
            if (mq.size() > 0) begin
                m_msg = mq.pop_front();
                m_mv  = 1;
                m_wc  = 0;
            end
        end else if (m_mv) begin
            if (bus.core_done) begin
                m_ct = bus.core_data;
                m_cv = 1;
                m_mv = 0;
            end else if (TMO_EN && m_wc == TMO - 1) begin
                m_mv   = 0;
                m_terr = 1;
            end else begin
                m_wc++;
            end
        end else if (bus.ct_ready) begin
            m_cv = 0;
            m_done++;
        end
        if (push) mq.push_back(pd);
    endtask

    task automatic compare();
        chk("fifo_count", bus.fifo_count, mq.size());
        chk("pt_ready", bus.pt_ready, mq.size() < DEPTH);
        chk("key_ready", bus.key_ready, !m_mv && !m_cv);
        chk("msg_valid", bus.msg_valid, m_mv);
        chk("msg_out", bus.msg_out, m_msg);
        chk("key_out", bus.key_out, m_key);
        chk("ct_valid", bus.ct_valid, m_cv);
        chk("ct_data", bus.ct_data, m_ct);
        chk("blocks_done", bus.blocks_done, m_done);
        chk("timeout_err", bus.timeout_err, m_terr);
    endtask

    task automatic drive();
        bus.pt_valid = ($urandom_range(99) < p_push);
        bus.pt_data  = rnd128();
        bus.key_load = ($urandom_range(99) < p_key);
        bus.key_in   = {rnd128(), rnd128()};
        bus.ct_ready = ($urandom_range(99) < p_ready);
        bus.core_done = 1'b0;
        bus.core_data = rnd128();
        if (bus.msg_valid === 1'b1) begin
            if (core_en) begin
                ctimer++;
                if (ctimer >= clat) begin
                    bus.core_done = 1'b1;
                    bus.core_data = fips ? FIPS_CT :
                        (bus.msg_out ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969);
                    ctimer = 0;
                    clat   = $urandom_range(lat_hi, lat_lo);
                end
            end
        end else begin
            ctimer = 0;
            bus.core_done = glitch && ($urandom_range(9) == 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic settle(int n);
        p_push = 0; p_key = 0; p_ready = 100;
        core_en = 1; glitch = 0;
        repeat (n) cyc();
    endtask

    task automatic push_blocks(int n);
        for (int i = 0; i < n; i++) begin
            bus.pt_valid = 1'b1;
            bus.pt_data  = rnd128();
            cyc();
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_msg_valid", bus.msg_valid, 0);
        chk("rst_ct_valid", bus.ct_valid, 0);
        chk("rst_msg_out", bus.msg_out, 0);
        chk("rst_ct_data", bus.ct_data, 0);
        chk("rst_key_out", bus.key_out, 0);
        chk("rst_blocks_done", bus.blocks_done, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_pt_ready", bus.pt_ready, 1);
        chk("rst_key_ready", bus.key_ready, 1);
        repeat (2) cyc();
        rst = 1'b1;
    endtask

    initial begin
        int k, n, idx;
        bit seen_full;
        logic [255:0] kold, knew;
        logic [15:0]  d0;
        logic [127:0] blk[6];

        bus.pt_valid = 0; bus.pt_data = '0;
        bus.key_load = 0; bus.key_in = '0;
        bus.core_done = 0; bus.core_data = '0;
        bus.ct_ready = 0;
        p_push = 0; p_key = 0; p_ready = 100;
        lat_lo = 1; lat_hi = 6; core_en = 1; glitch = 0; fips = 0;
        ctimer = 0; clat = 1;
        #1;
        do_reset();

        // FIPS-197 vector through a 20-cycle core
        settle(2);
        fips = 1; lat_lo = 20; lat_hi = 20; clat = 20;
        bus.key_in = FIPS_KEY; bus.key_load = 1'b1;
        bus.pt_valid = 1'b1; bus.pt_data = FIPS_PT;
        cyc();
        chk("fips_count_after_push", bus.fifo_count, 1);
        chk("fips_mv_at_push", bus.msg_valid, 0);
        cyc();
        chk("fips_mv_next_edge", bus.msg_valid, 1);
        chk("fips_msg_out", bus.msg_out, FIPS_PT);
        chk("fips_key_out", bus.key_out, FIPS_KEY);
        k = 0;
        while (bus.ct_valid !== 1'b1 && k < 40) begin cyc(); k++; end
        chk("fips_ct_valid", bus.ct_valid, 1);
        chk("fips_ct_data", bus.ct_data, FIPS_CT);
        cyc();
        chk("fips_blocks_done", bus.blocks_done, 1);
        chk("fips_ct_cleared", bus.ct_valid, 0);
        fips = 0; lat_lo = 1; lat_hi = 6; clat = 3;

        // FIFO full: core held off, 5 accepted, 6th stalled
        settle(10);
        core_en = 0;
        d0 = m_done;
        for (int i = 0; i < 6; i++) blk[i] = rnd128();
        idx = 0; seen_full = 0;
        bus.pt_valid = 1'b1; bus.pt_data = blk[0];
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (m_push) idx++;
            if (bus.fifo_count == 4 && !seen_full) begin
                seen_full = 1;
                chk("full_pt_ready_low", bus.pt_ready, 0);
            end
            if (idx < 6) begin
                bus.pt_valid = 1'b1; bus.pt_data = blk[idx];
            end
        end
        chk("full_count", bus.fifo_count, 4);
        chk("full_accepted", idx, 5);
        chk("full_in_flight", bus.msg_valid, 1);
        core_en = 1;
        k = 0;
        while ((idx < 6 || !bus.key_ready || bus.fifo_count != 0) && k < 300) begin
            cyc(); k++;
            if (m_push) idx++;
            if (idx < 6) begin
                bus.pt_valid = 1'b1; bus.pt_data = blk[idx];
            end
        end
        chk("full_drained", bus.blocks_done, d0 + 16'd6);

        // Backpressure: ct_ready low for 10 cycles
        settle(5);
        p_ready = 0; lat_lo = 3; lat_hi = 5; clat = 3;
        push_blocks(2);
        k = 0;
        while (bus.ct_valid !== 1'b1 && k < 60) begin cyc(); k++; end
        chk("bp_ct_valid", bus.ct_valid, 1);
        repeat (10) cyc();
        chk("bp_no_issue", bus.msg_valid, 0);
        chk("bp_queued", bus.fifo_count, 1);
        bus.ct_ready = 1'b1;
        cyc();
        chk("bp_ct_cleared", bus.ct_valid, 0);
        chk("bp_idle_mv", bus.msg_valid, 0);
        cyc();
        chk("bp_reissue", bus.msg_valid, 1);
        settle(30);

        // Key load ignored in WAIT, honoured in IDLE
        core_en = 0;
        push_blocks(1);
        k = 0;
        while (bus.msg_valid !== 1'b1 && k < 10) begin cyc(); k++; end
        kold = m_key;
        knew = {rnd128(), rnd128()};
        bus.key_load = 1'b1; bus.key_in = knew;
        cyc();
        chk("key_wait_ignored", bus.key_out, kold);
        core_en = 1;
        k = 0;
        while (bus.key_ready !== 1'b1 && k < 40) begin cyc(); k++; end
        bus.key_load = 1'b1; bus.key_in = knew;
        cyc();
        chk("key_idle_load", bus.key_out, knew);

        // Random traffic
        lat_lo = 1; lat_hi = 12;
        for (int s = 0; s < 6; s++) begin
            p_push = $urandom_range(90, 10);
            p_ready = $urandom_range(100, 20);
            p_key = 5; core_en = 1; glitch = 1;
            repeat (500) cyc();
        end

        // Mid-block reset with 2 queued
        settle(40);
        core_en = 0;
        push_blocks(3);
        k = 0;
        while (bus.msg_valid !== 1'b1 && k < 10) begin cyc(); k++; end
        cyc();
        chk("mrst_queued", bus.fifo_count, 2);
        do_reset();
        cyc();
        chk("mrst_count_after", bus.fifo_count, 0);
        chk("mrst_idle_after", bus.key_ready, 1);
        chk("mrst_mv_after", bus.msg_valid, 0);

        // Watchdog
        settle(5);
        core_en = 0;
        push_blocks(2);
`ifdef AES_SEQ_TIMEOUT_EN
        k = 0;
        while (bus.msg_valid !== 1'b1 && k < 20) begin cyc(); k++; end
        chk("wd_issue", bus.msg_valid, 1);
        d0 = m_done;
        n = 0;
        while (bus.msg_valid === 1'b1 && n < TMO + 10) begin cyc(); n++; end
        chk("wd_cycles", n, TMO);
        chk("wd_terr", bus.timeout_err, 1);
        chk("wd_blocks_same", bus.blocks_done, d0);
        cyc();
        chk("wd_next_issue", bus.msg_valid, 1);
        core_en = 1;
        repeat (40) cyc();
        chk("wd_terr_sticky", bus.timeout_err, 1);
`else
        n = 0;
        repeat (1100) cyc();
        chk("wd_off_mv_held", bus.msg_valid, 1);
        chk("wd_off_no_err", bus.timeout_err, 0);
        core_en = 1;
        repeat (40) cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
